pipelined_adder: RTL and testbench

- Parametrised N-bit adder, split into STAGES chunks with registered carry between chunks.
- One new operand pair is accepted per clock. Each result emerges STAGES cycles later.
- Valid/ready handshake on both sides with full backpressure.
- Next generation of the ripple-carry adders in combinational_ckt. Used wherever wide sums must close timing at speed.

---
 rtl/adder_pkg.sv | 23 ++
 rtl/adder_stage.sv | 44 ++++
 rtl/pipelined_adder.sv | 174 +++++++++++++++++
 tb/tb_pipelined_adder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the adders in combinational_ckt.
//   DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and pipeline depth
//   divisible()                    : true when WIDTH splits evenly into STAGES
//   chunk_width()                  : bits added per pipeline stage
// ---------------------------------------------------------------------------
package adder_pkg;

   localparam int unsigned DEFAULT_WIDTH  = 16;
   localparam int unsigned DEFAULT_STAGES = 4;

   function automatic bit divisible(input int unsigned width,
                                    input int unsigned stages);
      return (stages != 0) && (stages <= width) && ((width % stages) == 0);
   endfunction

   function automatic int unsigned chunk_width(input int unsigned width,
                                               input int unsigned stages);
      return (stages == 0) ? 0 : width / stages;
   endfunction

endpackage

// File: rtl/adder_stage.sv
// ---------------------------------------------------------------------------
// adder_stage
// One registered CHUNK-bit add slice of the pipelined adder.
//   clk, rst_n : clock, asynchronous active-low reset
//   advance    : pipeline enable; all registers hold while low
//   valid_in   : valid bit of the slot entering this stage
//   a, b, cin  : chunk operands and incoming carry
//   valid      : registered slot valid
//   sum, carry : registered chunk sum and carry-out
// ---------------------------------------------------------------------------
module adder_stage #(
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             advance,
   input  logic             valid_in,
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic             valid,
   output logic [CHUNK-1:0] sum,
   output logic             carry
);

   logic [CHUNK:0] total;

   always_comb begin
      total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         sum   <= '0;
         carry <= 1'b0;
      end else if (advance) begin
         valid <= valid_in;
         sum   <= total[CHUNK-1:0];
         carry <= total[CHUNK];
      end
   end

endmodule

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
// WIDTH-bit adder split into STAGES registered chunks, carry registered
// between chunks, valid/ready handshake with full backpressure.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready = !out_valid || out_ready)
//   A, B, Cin           : operands and carry-in to bit 0
//   sub                 : subtract select (only with PIPELINED_ADDER_SUB_EN)
//   out_valid/out_ready : result handshake
//   sum, carry          : A+B+Cin mod 2^WIDTH and unsigned carry-out
//   overflow            : signed overflow of the addition
// Optional feature macro: PIPELINED_ADDER_SUB_EN (adds the sub input; B is
// inverted per chunk, Cin passed unchanged, so Cin=1 gives A-B).
// ---------------------------------------------------------------------------
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH  = DEFAULT_WIDTH,
   parameter int unsigned STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef PIPELINED_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

   if (!divisible(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a multiple of STAGES");
   end

   logic advance;
   logic take;
   logic sub_in;

`ifdef PIPELINED_ADDER_SUB_EN
   assign sub_in = sub;
`else
   assign sub_in = 1'b0;
`endif

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   assign take     = in_valid && advance;

   // Stage k owns operand bits [WIDTH-1:LO] on its input side: chunk k is
   // added here, the rest rides along in g_up. Already-computed lower sum
   // chunks ride along in g_low so the full sum lines up at the output.
   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam int unsigned LO = k * CHUNK;
      localparam int unsigned HI = LO + CHUNK;

      logic [WIDTH-1:LO] a_src;
      logic [WIDTH-1:LO] b_src;
      logic              c_in;
      logic              v_in;
      logic              s_in;
      logic [CHUNK-1:0]  a_chunk;
      logic [CHUNK-1:0]  b_eff;
      logic              valid;
      logic [CHUNK-1:0]  chunk;
      logic              carry_q;

      if (k == 0) begin : g_src
         assign a_src = A;
         assign b_src = B;
         assign c_in  = Cin;
         assign v_in  = take;
         assign s_in  = sub_in;
      end else begin : g_src
         assign a_src = stg[k-1].g_up.a_up;
         assign b_src = stg[k-1].g_up.b_up;
         assign c_in  = stg[k-1].carry_q;
         assign v_in  = stg[k-1].valid;
         assign s_in  = stg[k-1].g_up.sub_q;
      end

      assign a_chunk = a_src[HI-1:LO];
      assign b_eff   = b_src[HI-1:LO] ^ {CHUNK{s_in}};

      adder_stage #(
         .CHUNK (CHUNK)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .advance  (advance),
         .valid_in (v_in),
         .a        (a_chunk),
         .b        (b_eff),
         .cin      (c_in),
         .valid    (valid),
         .sum      (chunk),
         .carry    (carry_q)
      );

      if (k < STAGES - 1) begin : g_up
         logic [WIDTH-1:HI] a_up;
         logic [WIDTH-1:HI] b_up;
         logic              sub_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_up  <= '0;
               b_up  <= '0;
               sub_q <= 1'b0;
            end else if (advance) begin
               a_up  <= a_src[WIDTH-1:HI];
               b_up  <= b_src[WIDTH-1:HI];
               sub_q <= s_in;
            end
         end
      end

      if (k > 0) begin : g_low
         logic [LO-1:0] low_next;
         logic [LO-1:0] low_q;

         if (k == 1) begin : g_cat
            assign low_next = stg[0].chunk;
         end else begin : g_cat
            assign low_next = {stg[k-1].chunk, stg[k-1].g_low.low_q};
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               low_q <= '0;
            end else if (advance) begin
               low_q <= low_next;
            end
         end
      end

      // Operand MSBs (B after optional inversion) kept beside the top chunk
      // so overflow can be formed from the registered sum MSB.
      if (k == STAGES - 1) begin : g_msb
         logic a_msb_q;
         logic b_msb_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_msb_q <= 1'b0;
               b_msb_q <= 1'b0;
            end else if (advance) begin
               a_msb_q <= a_chunk[CHUNK-1];
               b_msb_q <= b_eff[CHUNK-1];
            end
         end
      end
   end

   if (STAGES == 1) begin : g_sum
      assign sum = stg[0].chunk;
   end else begin : g_sum
      assign sum = {stg[STAGES-1].chunk, stg[STAGES-1].g_low.low_q};
   end

   assign out_valid = stg[STAGES-1].valid;
   assign carry     = stg[STAGES-1].carry_q;
   assign overflow  = (stg[STAGES-1].g_msb.a_msb_q == stg[STAGES-1].g_msb.b_msb_q) &&
                      (sum[WIDTH-1] != stg[STAGES-1].g_msb.a_msb_q);

endmodule

// File: tb/tb_pipelined_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4): directed
// table of hand-computed sums, a back-to-back stream, a backpressure stream,
// mid-flight reset and, with PIPELINED_ADDER_SUB_EN, subtraction vectors.
// ---------------------------------------------------------------------------
module tb_pipelined_adder;

   localparam int unsigned W   = 16;
   localparam int unsigned LAT = 4;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         o;
      int           cyc;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         cin_i;
   logic         sub_i;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         carry;
   logic         overflow;

   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;
   int   bp_idx = 0;
   bit   chk_lat;
   bit   prev_stall;
   logic [W-1:0] held_sum;
   logic         held_c;
   logic         held_o;
   exp_t cur;
   exp_t q[$];
   vec_t tbl[10];

   always #5 clk = ~clk;

   pipelined_adder #(
      .WIDTH  (16),
      .STAGES (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a_i),
      .B         (b_i),
      .Cin       (cin_i),
`ifdef PIPELINED_ADDER_SUB_EN
      .sub       (sub_i),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry),
      .overflow  (overflow)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic note_fail(input string name, input int info);
      checks++;
      fails++;
      $display("FAIL %s: info %0d (cycle %0d)", name, info, cyc);
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic s);
      exp_t e;
      logic [W-1:0] bb;
      logic [W:0]   t;
      bb  = s ? ~b : b;
      t   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
      e.s = t[W-1:0];
      e.c = t[W];
      e.o = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
      e.cyc = 0;
      return e;
   endfunction

   function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
      exp_t e;
      e.s = s; e.c = c; e.o = o; e.cyc = 0;
      return e;
   endfunction

   // One clock: sample at the negedge, then let the posedge happen.
   task automatic step(output bit xfer);
      exp_t e;
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (prev_stall) begin
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_sum", 32'(sum), 32'(held_sum));
         chk("hold_carry", 32'(carry), 32'(held_c));
         chk("hold_ovf", 32'(overflow), 32'(held_o));
      end
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            note_fail("spurious_output", 32'(sum));
         end else begin
            e = q.pop_front();
            chk("sum", 32'(sum), 32'(e.s));
            chk("carry", 32'(carry), 32'(e.c));
            chk("overflow", 32'(overflow), 32'(e.o));
            if (chk_lat) chk("latency", 32'(cyc - e.cyc), LAT);
         end
      end
      prev_stall = out_valid && !out_ready;
      held_sum   = sum;
      held_c     = carry;
      held_o     = overflow;
      xfer       = in_valid && in_ready;
      if (xfer) begin
         e     = cur;
         e.cyc = cyc;
         q.push_back(e);
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic set_ready(input bit rnd);
      if (!rnd)                         out_ready = 1'b1;
      else if (bp_idx >= 3 && bp_idx < 8) out_ready = 1'b0;
      else                              out_ready = 1'($urandom_range(0, 1));
      bp_idx++;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic s, input exp_t e, input bit rnd);
      bit x;
      int n;
      n        = 0;
      a_i      = a;
      b_i      = b;
      cin_i    = c;
      sub_i    = s;
      cur      = e;
      in_valid = 1'b1;
      do begin
         set_ready(rnd);
         step(x);
         n++;
      end while (!x && n < 60);
      if (!x) note_fail("send_timeout", n);
      in_valid = 1'b0;
   endtask

   task automatic drain(input bit rnd);
      bit x;
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         set_ready(rnd);
         step(x);
         n++;
      end
      if (q.size() != 0) note_fail("drain_timeout", q.size());
   endtask

   task automatic idle(input int n);
      bit x;
      for (int i = 0; i < n; i++) begin
         out_ready = 1'b1;
         step(x);
      end
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;

      tbl[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
      tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
      tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      tbl[6] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};
      tbl[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
      tbl[8] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      tbl[9] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};

      rst_n      = 1'b1;
      in_valid   = 1'b0;
      a_i        = '0;
      b_i        = '0;
      cin_i      = 1'b0;
      sub_i      = 1'b0;
      out_ready  = 1'b1;
      chk_lat    = 1'b1;
      prev_stall = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_carry", 32'(carry), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed table, one transfer at a time, latency checked.
      for (int i = 0; i < 10; i++) begin
         send(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, mk(tbl[i].s, tbl[i].c, tbl[i].o), 1'b0);
         drain(1'b0);
      end

      // 20 back-to-back random pairs with out_ready held high.
      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(0, 1));
         send(ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0), 1'b0);
      end
      drain(1'b0);

      // Backpressure: 10 pairs, random out_ready with a 5-cycle low run.
      chk_lat = 1'b0;
      bp_idx  = 0;
      for (int i = 0; i < 10; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(0, 1));
         send(ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0), 1'b1);
      end
      drain(1'b1);
      idle(1);
      chk_lat = 1'b1;

      // Reset with three results in flight, the oldest already at the output.
      send(16'h0100, 16'h0200, 1'b0, 1'b0, mk(16'h0300, 1'b0, 1'b0), 1'b0);
      send(16'h0101, 16'h0202, 1'b0, 1'b0, mk(16'h0303, 1'b0, 1'b0), 1'b0);
      send(16'h0102, 16'h0204, 1'b0, 1'b0, mk(16'h0306, 1'b0, 1'b0), 1'b0);
      out_ready = 1'b0;
      begin
         bit x;
         step(x);
      end
      #1;
      chk("pre_reset_valid", 32'(out_valid), 32'd1);
      chk("pre_reset_sum", 32'(sum), 32'h0300);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_sum", 32'(sum), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
      q.delete();
      prev_stall = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(8);
      send(16'h4000, 16'h4000, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1), 1'b0);
      drain(1'b0);
      idle(2);

`ifdef PIPELINED_ADDER_SUB_EN
      send(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0), 1'b0);
      drain(1'b0);
      send(16'h8000, 16'h0001, 1'b1, 1'b1, mk(16'h7FFF, 1'b1, 1'b1), 1'b0);
      drain(1'b0);
      for (int i = 0; i < 8; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(0, 1));
         send(ra, rb, rc, 1'(i % 2), model(ra, rb, rc, 1'(i % 2)), 1'b0);
      end
      drain(1'b0);
      idle(2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
